survivor_select_out: RTL and testbench

//   Final stage of the Viterbi decoder, directly downstream of cs. Takes the four accumulated path metrics
//   and 8-bit survivor path registers (new_branch_metric_xx / updated_selected_branch_at_xx).

---
 rtl/survivor_select_out_pkg.sv | 19 +
 rtl/survivor_select_out_if.sv | 44 ++++
 rtl/survivor_select_out_min4_select.sv | 36 +++
 rtl/survivor_select_out.sv | 130 +++++++++++++
 tb/tb_survivor_select_out.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/survivor_select_out_pkg.sv
// Shared definitions for the Viterbi output stage: default widths, trellis state codes, FSM encoding.
package survivor_select_out_pkg;

  localparam int unsigned DEF_METRIC_W = 4;
  localparam int unsigned DEF_PATH_W   = 8;
  localparam int unsigned NUM_STATES   = 4;

  localparam logic [1:0] S00 = 2'd0;
  localparam logic [1:0] S01 = 2'd1;
  localparam logic [1:0] S10 = 2'd2;
  localparam logic [1:0] S11 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/survivor_select_out_if.sv
// Metric/path input bundle and decoded-bit output stream of the survivor select stage.
interface survivor_select_out_if
  import survivor_select_out_pkg::*;
#(
  parameter int unsigned METRIC_W = DEF_METRIC_W,
  parameter int unsigned PATH_W   = DEF_PATH_W
);

  logic                valid_in;
  logic                ready_in;
  logic [METRIC_W-1:0] metric_00;
  logic [METRIC_W-1:0] metric_01;
  logic [METRIC_W-1:0] metric_10;
  logic [METRIC_W-1:0] metric_11;
  logic [PATH_W-1:0]   path_00;
  logic [PATH_W-1:0]   path_01;
  logic [PATH_W-1:0]   path_10;
  logic [PATH_W-1:0]   path_11;
  logic                bit_out;
  logic                bit_valid;
  logic                bit_ready;
  logic                bit_last;
  logic [1:0]          best_state;
  logic [METRIC_W-1:0] best_metric;
  logic                frame_done;
  logic [7:0]          frame_count;

  // Environment side: supplies bundles, consumes bits.
  modport master (
    output valid_in, metric_00, metric_01, metric_10, metric_11,
           path_00, path_01, path_10, path_11, bit_ready,
    input  ready_in, bit_out, bit_valid, bit_last, best_state, best_metric,
           frame_done, frame_count
  );

  // Decoder side.
  modport slave (
    input  valid_in, metric_00, metric_01, metric_10, metric_11,
           path_00, path_01, path_10, path_11, bit_ready,
    output ready_in, bit_out, bit_valid, bit_last, best_state, best_metric,
           frame_done, frame_count
  );

endinterface

// File: rtl/survivor_select_out_min4_select.sv
// Combinational 4-way unsigned minimum; ties resolve to the lowest state index.
module min4_select
  import survivor_select_out_pkg::*;
#(
  parameter int unsigned W = DEF_METRIC_W
) (
  input  logic [NUM_STATES-1:0][W-1:0] m,
  output logic [1:0]                   idx,
  output logic [W-1:0]                 min_val
);

  logic          lo_pick_hi_c;
  logic          hi_pick_hi_c;
  logic [W-1:0]  lo_val_c;
  logic [W-1:0]  hi_val_c;
  logic [1:0]    lo_idx_c;
  logic [1:0]    hi_idx_c;

  // Pairwise tree; '<=' keeps the lower index on equal metrics at every level.
  always_comb begin
    lo_pick_hi_c = !(m[0] <= m[1]);
    hi_pick_hi_c = !(m[2] <= m[3]);
    lo_val_c     = lo_pick_hi_c ? m[1] : m[0];
    lo_idx_c     = lo_pick_hi_c ? S01  : S00;
    hi_val_c     = hi_pick_hi_c ? m[3] : m[2];
    hi_idx_c     = hi_pick_hi_c ? S11  : S10;
    if (lo_val_c <= hi_val_c) begin
      idx     = lo_idx_c;
      min_val = lo_val_c;
    end else begin
      idx     = hi_idx_c;
      min_val = hi_val_c;
    end
  end

endmodule

// File: rtl/survivor_select_out.sv
// Viterbi final stage: pick the minimum-metric trellis state and stream its survivor path out bit by bit.
module survivor_select_out
  import survivor_select_out_pkg::*;
#(
  parameter int unsigned METRIC_W  = DEF_METRIC_W,
  parameter int unsigned PATH_W    = DEF_PATH_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  survivor_select_out_if.slave bus
);

  localparam int unsigned CNT_W = (PATH_W > 1) ? $clog2(PATH_W) : 1;

  state_e                              state_q, state_d;
  logic [NUM_STATES-1:0][METRIC_W-1:0] metric_q, metric_d;
  logic [NUM_STATES-1:0][PATH_W-1:0]   path_q, path_d;
  logic [PATH_W-1:0]                   shreg_q, shreg_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                ready_q, ready_d;
  logic                                valid_q, valid_d;
  logic                                last_q, last_d;
  logic                                done_q, done_d;
  logic [1:0]                          best_state_q, best_state_d;
  logic [METRIC_W-1:0]                 best_metric_q, best_metric_d;
  logic [7:0]                          fcount_q, fcount_d;
  logic [1:0]                          min_idx_c;
  logic [METRIC_W-1:0]                 min_val_c;

  min4_select #(.W(METRIC_W)) u_min4 (
    .m       (metric_q),
    .idx     (min_idx_c),
    .min_val (min_val_c)
  );

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      metric_q      <= '0;
      path_q        <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      fcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      metric_q      <= metric_d;
      path_q        <= path_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      done_q        <= done_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      fcount_q      <= fcount_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    metric_d      = metric_q;
    path_d        = path_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    best_state_d  = best_state_q;
    best_metric_d = best_metric_q;
    fcount_d      = fcount_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in && ready_q) begin
          metric_d[0] = bus.metric_00;
          metric_d[1] = bus.metric_01;
          metric_d[2] = bus.metric_10;
          metric_d[3] = bus.metric_11;
          path_d[0]   = bus.path_00;
          path_d[1]   = bus.path_01;
          path_d[2]   = bus.path_10;
          path_d[3]   = bus.path_11;
          state_d     = CMP;
        end
      end
      CMP: begin
        best_state_d  = min_idx_c;
        best_metric_d = min_val_c;
        shreg_d       = path_q[min_idx_c];
        cnt_d         = CNT_W'(PATH_W - 1);
        state_d       = SHIFT;
      end
      SHIFT: begin
        if (valid_q && bus.bit_ready) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (cnt_q == '0) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            fcount_d = fcount_q + 8'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == SHIFT);
    last_d  = (state_d == SHIFT) && (cnt_d == '0);
  end

  assign bus.ready_in    = ready_q;
  assign bus.bit_valid   = valid_q;
  assign bus.bit_last    = last_q;
  assign bus.bit_out     = MSB_FIRST ? shreg_q[PATH_W-1] : shreg_q[0];
  assign bus.best_state  = best_state_q;
  assign bus.best_metric = best_metric_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = fcount_q;

endmodule

// File: tb/tb_survivor_select_out.sv
// Bench for survivor_select_out: directed vector table, busy/reset sequences, random frames and a 257-frame run.
module tb_survivor_select_out;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  logic [7:0] exp_fc;

  survivor_select_out_if bus ();

  survivor_select_out dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0][3:0] m;
    logic [3:0][7:0] p;
    int              mode;
    logic [1:0]      es;
    logic [3:0]      em;
    logic [7:0]      eb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0][3:0] mk_m(input int a, input int b, input int c, input int d);
    logic [3:0][3:0] r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d);
    return r;
  endfunction

  function automatic logic [3:0][7:0] mk_p(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    logic [3:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Reference: first strictly-smaller metric wins, so equal metrics keep the lowest index;
  // the winning path is emitted MSB first, so the assembled stream equals the path itself.
  function automatic void model(input logic [3:0][3:0] m, input logic [3:0][7:0] p,
                                output logic [1:0] s, output logic [3:0] v, output logic [7:0] bits);
    s = 2'd0;
    v = m[0];
    for (int i = 1; i < 4; i++) begin
      if (m[i] < v) begin
        s = 2'(i);
        v = m[i];
      end
    end
    bits = p[s];
  endfunction

  task automatic drive(input logic [3:0][3:0] m, input logic [3:0][7:0] p);
    bus.metric_00 = m[0]; bus.metric_01 = m[1]; bus.metric_10 = m[2]; bus.metric_11 = m[3];
    bus.path_00   = p[0]; bus.path_01   = p[1]; bus.path_10   = p[2]; bus.path_11   = p[3];
  endtask

  task automatic rand_bundle(output logic [3:0][3:0] m, output logic [3:0][7:0] p);
    int hi;
    hi = ($urandom_range(0, 1) == 1) ? 3 : 15;
    for (int i = 0; i < 4; i++) begin
      m[i] = 4'($urandom_range(0, hi));
      p[i] = 8'($urandom);
    end
  endtask

  // One full frame: accept (unless already accepted), stream 8 bits under the chosen bit_ready pattern.
  task automatic do_frame(input logic [3:0][3:0] m, input logic [3:0][7:0] p, input int mode,
                          input bit busy, input bit pre,
                          input logic [1:0] es, input logic [3:0] em, input logic [7:0] eb);
    int guard;
    int k;
    int n_xfer;
    logic [7:0] got;
    logic [7:0] lastmask;
    bit held_pending;
    bit br;
    logic held_bit;
    logic held_last;
    got = '0; lastmask = '0; n_xfer = 0; held_pending = 0; k = 0;
    if (!pre) begin
      guard = 0;
      while (!bus.ready_in && guard < 40) begin
        step();
        guard++;
      end
      chk("accept_ready", 32'(bus.ready_in), 1);
      drive(m, p);
      bus.valid_in = 1'b1;
      step();
    end
    chk("cmp_ready_low", 32'(bus.ready_in), 0);
    chk("cmp_no_valid", 32'(bus.bit_valid), 0);
    if (busy) begin
      drive(mk_m(0, 0, 0, 0), mk_p(8'h5A, 8'h11, 8'h22, 8'h33));
      bus.valid_in = 1'b1;
    end else begin
      bus.valid_in = 1'b0;
    end
    step();
    while (n_xfer < 8 && k < 64) begin
      case (mode)
        0:       br = 1'b1;
        1:       br = (k % 2 == 0);
        default: br = 1'($urandom_range(0, 1));
      endcase
      bus.bit_ready = br;
      chk("bit_valid", 32'(bus.bit_valid), 1);
      if (k == 0) begin
        chk("best_state", 32'(bus.best_state), 32'(es));
        chk("best_metric", 32'(bus.best_metric), 32'(em));
      end
      if (held_pending) begin
        chk("hold_bit", 32'(bus.bit_out), 32'(held_bit));
        chk("hold_last", 32'(bus.bit_last), 32'(held_last));
        held_pending = 0;
      end
      if (busy) chk("busy_ready_low", 32'(bus.ready_in), 0);
      if (br) begin
        got = {got[6:0], bus.bit_out};
        if (bus.bit_last) lastmask = lastmask | (8'd1 << n_xfer);
        n_xfer++;
      end else begin
        held_pending = 1;
        held_bit     = bus.bit_out;
        held_last    = bus.bit_last;
      end
      step();
      k++;
    end
    chk("bits", 32'(got), 32'(eb));
    chk("last_pos", 32'(lastmask), 32'h80);
    if (mode < 2) chk("beat_cycles", 32'(k), (mode == 0) ? 32'd8 : 32'd15);
    exp_fc = exp_fc + 8'd1;
    chk("frame_done", 32'(bus.frame_done), 1);
    chk("valid_drop", 32'(bus.bit_valid), 0);
    chk("ready_back", 32'(bus.ready_in), 1);
    chk("frame_count", 32'(bus.frame_count), 32'(exp_fc));
    bus.bit_ready = 1'b1;
    step();
    chk("done_pulse", 32'(bus.frame_done), 0);
    chk("best_hold", 32'({bus.best_state, bus.best_metric}), 32'({es, em}));
  endtask

  // Continuous traffic: valid_in held high, bit_ready stuck at 1, fresh random bundle after each accept.
  task automatic b2b(input int nframes);
    logic [3:0][3:0] m;
    logic [3:0][7:0] p;
    logic [1:0] s;
    logic [3:0] v;
    logic [7:0] eb;
    logic [7:0] got;
    logic [7:0] q_bits [$];
    logic [7:0] prev_fc;
    int acc_n, done_n, last_acc, nbit, guard;
    bit acc_now, wrap0, wrap1;
    acc_n = 0; done_n = 0; last_acc = -1; nbit = 0; guard = 0; got = '0;
    wrap0 = 0; wrap1 = 0; prev_fc = bus.frame_count;
    rand_bundle(m, p);
    drive(m, p);
    bus.valid_in  = 1'b1;
    bus.bit_ready = 1'b1;
    while (done_n < nframes && guard < nframes * 12 + 40) begin
      if (bus.bit_valid) begin
        if (nbit == 0) chk("first_bit_latency", 32'(cyc + 1 - last_acc), 2);
        got = {got[6:0], bus.bit_out};
        nbit++;
        if (nbit == 8) begin
          eb = (q_bits.size() > 0) ? q_bits.pop_front() : 8'hxx;
          chk("b2b_bits", 32'(got), 32'(eb));
          nbit = 0;
          exp_fc = exp_fc + 8'd1;
          done_n++;
        end
      end
      if (bus.frame_done) begin
        chk("b2b_count", 32'(bus.frame_count), 32'(exp_fc));
        if (prev_fc == 8'd255 && bus.frame_count == 8'd0) wrap0 = 1;
        if (wrap0 && prev_fc == 8'd0 && bus.frame_count == 8'd1) wrap1 = 1;
        prev_fc = bus.frame_count;
      end
      acc_now = bus.valid_in && bus.ready_in;
      step();
      guard++;
      if (acc_now) begin
        if (last_acc >= 0) chk("frame_period", 32'(cyc - last_acc), 10);
        last_acc = cyc;
        model(m, p, s, v, eb);
        q_bits.push_back(eb);
        acc_n++;
        if (acc_n == nframes) begin
          bus.valid_in = 1'b0;
        end else begin
          rand_bundle(m, p);
          drive(m, p);
        end
      end
    end
    chk("b2b_frames", 32'(done_n), 32'(nframes));
    chk("count_wrap", 32'({wrap0, wrap1}), 32'b11);
  endtask

  initial begin
    logic [3:0][3:0] m;
    logic [3:0][7:0] p;
    logic [1:0] s;
    logic [3:0] v;
    logic [7:0] eb;
    n_cmp = 0; n_bad = 0; cyc = 0; exp_fc = '0;
    rst = 1'b0;
    bus.valid_in = 1'b0; bus.bit_ready = 1'b1;
    drive(mk_m(0, 0, 0, 0), mk_p(8'h00, 8'h00, 8'h00, 8'h00));

    vecs[0] = '{mk_m(5, 3, 7, 9),   mk_p(8'hAA, 8'hCC, 8'hF0, 8'h0F), 0, 2'd1, 4'd3, 8'hCC};
    vecs[1] = '{mk_m(2, 2, 2, 2),   mk_p(8'h80, 8'hFF, 8'hFF, 8'hFF), 0, 2'd0, 4'd2, 8'h80};
    vecs[2] = '{mk_m(5, 3, 7, 9),   mk_p(8'hAA, 8'hCC, 8'hF0, 8'h0F), 1, 2'd1, 4'd3, 8'hCC};
    vecs[3] = '{mk_m(9, 9, 4, 4),   mk_p(8'h11, 8'h22, 8'h33, 8'h44), 0, 2'd2, 4'd4, 8'h33};
    vecs[4] = '{mk_m(15, 14, 15, 0), mk_p(8'h01, 8'h02, 8'h03, 8'hC3), 0, 2'd3, 4'd0, 8'hC3};
    vecs[5] = '{mk_m(1, 0, 0, 0),   mk_p(8'h00, 8'h7E, 8'h81, 8'hFF), 1, 2'd1, 4'd0, 8'h7E};

    // Reset state, then ready_in rises on the first edge after release.
    step();
    step();
    chk("rst_ready", 32'(bus.ready_in), 0);
    chk("rst_valid", 32'(bus.bit_valid), 0);
    chk("rst_outs", 32'({bus.bit_out, bus.bit_last, bus.frame_done}), 0);
    chk("rst_best", 32'({bus.best_state, bus.best_metric}), 0);
    chk("rst_count", 32'(bus.frame_count), 0);
    rst = 1'b1;
    #1;
    chk("rel_ready_low", 32'(bus.ready_in), 0);
    step();
    chk("rel_ready_high", 32'(bus.ready_in), 1);

    for (int i = 0; i < 6; i++)
      do_frame(vecs[i].m, vecs[i].p, vecs[i].mode, 1'b0, 1'b0, vecs[i].es, vecs[i].em, vecs[i].eb);

    // Busy: a zero-metric bundle held during SHIFT is taken only once the stage is idle again.
    do_frame(vecs[0].m, vecs[0].p, 0, 1'b1, 1'b0, 2'd1, 4'd3, 8'hCC);
    do_frame(mk_m(0, 0, 0, 0), mk_p(8'h5A, 8'h11, 8'h22, 8'h33), 0, 1'b0, 1'b1, 2'd0, 4'd0, 8'h5A);

    for (int i = 0; i < 20; i++) begin
      rand_bundle(m, p);
      model(m, p, s, v, eb);
      do_frame(m, p, 2, 1'b0, 1'b0, s, v, eb);
    end

    // Mid-frame reset after three transferred bits.
    drive(vecs[0].m, vecs[0].p);
    bus.valid_in = 1'b1;
    bus.bit_ready = 1'b1;
    step();
    bus.valid_in = 1'b0;
    step();
    step();
    step();
    step();
    chk("pre_rst_valid", 32'(bus.bit_valid), 1);
    rst = 1'b0;
    #1;
    exp_fc = '0;
    chk("abort_valid", 32'(bus.bit_valid), 0);
    chk("abort_count", 32'(bus.frame_count), 0);
    chk("abort_done", 32'(bus.frame_done), 0);
    chk("abort_ready", 32'(bus.ready_in), 0);
    step();
    chk("abort_no_done", 32'(bus.frame_done), 0);
    rst = 1'b1;
    chk("abort_rel_ready_low", 32'(bus.ready_in), 0);
    step();
    chk("abort_rel_ready", 32'(bus.ready_in), 1);
    do_frame(vecs[1].m, vecs[1].p, 0, 1'b0, 1'b0, vecs[1].es, vecs[1].em, vecs[1].eb);

    b2b(257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
